// File: rtl/tictac_board.sv
// Board state, move validation and random-cell arbitration for the 3x3 tic-tac-toe game.
// Commits land on the request edge; win/tie for a commit are resolved on the following edge.
module tictac_board #(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        new_game,
   input  logic [3:0]  cell_sel,
   input  logic        validate_play,
   input  logic        play_random,
   input  logic        change_turn,
   output logic        v,
   output logic        win,
   output logic        tie,
   output logic        player,
   output logic [17:0] board,
   output logic [7:0]  win_line,
   output logic [3:0]  move_count
);

   logic [17:0] board_q, board_d;
   logic        player_q, player_d;
   logic        v_q, v_d;
   logic        win_q, win_d;
   logic        tie_q, tie_d;
   logic [7:0]  winLine_q, winLine_d;
   logic [3:0]  count_q, count_d;
   logic [7:0]  lfsr_q, lfsr_d;
   logic        evalPending_q, evalPending_d;
   logic [1:0]  evalMark_q, evalMark_d;

   logic [8:0]  cellEmpty;
   logic [8:0]  owned;
   logic [15:0] emptyPad;
   logic [7:0]  lines;
   logic [3:0]  startIdx;
   logic [3:0]  randCell;
   logic        randFound;
   logic [4:0]  probe;
   logic        gameOver;
   logic        selLegal;
   logic [1:0]  playerMark;
   logic        writeEn;
   logic [3:0]  writeCell;

   // owned[] tracks the mark of the most recent commit so the line check only looks at that mover
   always_comb begin
      cellEmpty = '0;
      owned     = '0;
      for (int k = 0; k < 9; k++) begin
         cellEmpty[k] = (board_q[2*k +: 2] == 2'b00);
         owned[k]     = (board_q[2*k +: 2] == evalMark_q);
      end
   end

   assign emptyPad = {7'b0, cellEmpty};

   assign lines[0] = owned[0] & owned[1] & owned[2];
   assign lines[1] = owned[3] & owned[4] & owned[5];
   assign lines[2] = owned[6] & owned[7] & owned[8];
   assign lines[3] = owned[0] & owned[3] & owned[6];
   assign lines[4] = owned[1] & owned[4] & owned[7];
   assign lines[5] = owned[2] & owned[5] & owned[8];
   assign lines[6] = owned[0] & owned[4] & owned[8];
   assign lines[7] = owned[2] & owned[4] & owned[6];

   assign lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   assign startIdx   = (lfsr_q[3:0] >= 4'd9) ? (lfsr_q[3:0] - 4'd9) : lfsr_q[3:0];
   assign gameOver   = win_q | tie_q;
   assign playerMark = player_q ? 2'b10 : 2'b01;
   assign selLegal   = (cell_sel <= 4'd8) && emptyPad[cell_sel] && !gameOver;

   // Scan offsets from far to near so the nearest empty cell after the start index wins
   always_comb begin
      randFound = 1'b0;
      randCell  = 4'd0;
      probe     = 5'd0;
      for (int i = 8; i >= 0; i--) begin
         probe = {1'b0, startIdx} + 5'(i);
         if (probe >= 5'd9) begin
            probe = probe - 5'd9;
         end
         if (emptyPad[probe[3:0]]) begin
            randFound = 1'b1;
            randCell  = probe[3:0];
         end
      end
   end

   always_comb begin
      writeEn   = 1'b0;
      writeCell = cell_sel;
      v_d       = v_q;
      if (new_game) begin
         v_d = 1'b0;
      end else if (validate_play) begin
         v_d     = selLegal;
         writeEn = selLegal;
      end else if (play_random) begin
         v_d       = randFound && !gameOver;
         writeEn   = randFound && !gameOver;
         writeCell = randCell;
      end
   end

   always_comb begin
      board_d       = board_q;
      count_d       = count_q;
      player_d      = player_q ^ change_turn;
      win_d         = win_q;
      tie_d         = tie_q;
      winLine_d     = winLine_q;
      evalPending_d = writeEn;
      evalMark_d    = writeEn ? playerMark : evalMark_q;

      if (evalPending_q && !gameOver) begin
         if (|lines) begin
            win_d     = 1'b1;
            winLine_d = lines & (~lines + 8'd1);
         end else if (count_q == 4'd9) begin
            tie_d = 1'b1;
         end
      end

      if (writeEn) begin
         board_d[{writeCell, 1'b0} +: 2] = playerMark;
         count_d                         = count_q + 4'd1;
      end

      if (new_game) begin
         board_d       = '0;
         count_d       = '0;
         player_d      = 1'b0;
         win_d         = 1'b0;
         tie_d         = 1'b0;
         winLine_d     = '0;
         evalPending_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         board_q       <= '0;
         player_q      <= 1'b0;
         v_q           <= 1'b0;
         win_q         <= 1'b0;
         tie_q         <= 1'b0;
         winLine_q     <= '0;
         count_q       <= '0;
         lfsr_q        <= SEED;
         evalPending_q <= 1'b0;
         evalMark_q    <= 2'b00;
      end else begin
         board_q       <= board_d;
         player_q      <= player_d;
         v_q           <= v_d;
         win_q         <= win_d;
         tie_q         <= tie_d;
         winLine_q     <= winLine_d;
         count_q       <= count_d;
         lfsr_q        <= lfsr_d;
         evalPending_q <= evalPending_d;
         evalMark_q    <= evalMark_d;
      end
   end

   assign v          = v_q;
   assign win        = win_q;
   assign tie        = tie_q;
   assign player     = player_q;
   assign board      = board_q;
   assign win_line   = winLine_q;
   assign move_count = count_q;

endmodule

// File: tb/tb_tictac_board.sv
// Scoreboard bench for tictac_board: a game-level reference model predicts every cycle's outputs,
// a monitor compares them one step after each rising edge.
module tb_tictac_board;

   localparam logic [7:0] SEED = 8'hA5;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        newGame = 1'b0;
   logic [3:0]  cellSel = 4'd0;
   logic        validatePlay = 1'b0;
   logic        playRandom = 1'b0;
   logic        changeTurn = 1'b0;
   logic        v, win, tie, player;
   logic [17:0] board;
   logic [7:0]  winLine;
   logic [3:0]  moveCount;

   always #5 clk = ~clk;

   tictac_board #(.SEED(SEED)) dut (
      .clk          (clk),
      .rst          (rst),
      .new_game     (newGame),
      .cell_sel     (cellSel),
      .validate_play(validatePlay),
      .play_random  (playRandom),
      .change_turn  (changeTurn),
      .v            (v),
      .win          (win),
      .tie          (tie),
      .player       (player),
      .board        (board),
      .win_line     (winLine),
      .move_count   (moveCount)
   );

   typedef struct packed {
      logic        v;
      logic        win;
      logic        tie;
      logic        player;
      logic [17:0] board;
      logic [7:0]  winLine;
      logic [3:0]  count;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   // Game-level reference: cells hold 0 empty, 1 X, 2 O; mPend is the mark awaiting line evaluation
   int         mBoard[9];
   int         mPlayer;
   int         mCount;
   int         mPend;
   logic       mV, mWin, mTie;
   logic [7:0] mWinLine;
   logic [7:0] mLfsr;
   int         lineCells[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                                   '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
   int         lfsrTaps[4] = '{8, 6, 5, 4};

   function automatic logic [7:0] lfsrNext(input logic [7:0] s);
      logic fb;
      fb = 1'b0;
      for (int t = 0; t < 4; t++) fb = fb ^ s[lfsrTaps[t] - 1];
      return {s[6:0], fb};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelClearGame();
      for (int k = 0; k < 9; k++) mBoard[k] = 0;
      mPlayer = 0; mCount = 0; mPend = 0;
      mV = 1'b0; mWin = 1'b0; mTie = 1'b0; mWinLine = 8'h00;
   endtask

   task automatic modelEdge(input logic ng, input logic [3:0] cs, input logic vp, input logic pr, input logic ct);
      logic [7:0] useL;
      logic       oldWin, oldTie;
      int         firstLine, c, s, idx;
      exp_t       e;
      useL  = mLfsr;
      mLfsr = lfsrNext(mLfsr);
      if (ng) begin
         modelClearGame();
      end else begin
         oldWin = mWin;
         oldTie = mTie;
         if (mPend != 0) begin
            firstLine = -1;
            for (int l = 7; l >= 0; l--)
               if (mBoard[lineCells[l][0]] == mPend && mBoard[lineCells[l][1]] == mPend &&
                   mBoard[lineCells[l][2]] == mPend) firstLine = l;
            if (firstLine >= 0 && !oldWin && !oldTie) begin
               mWin     = 1'b1;
               mWinLine = 8'(1 << firstLine);
            end else if (firstLine < 0 && mCount == 9 && !oldWin) begin
               mTie = 1'b1;
            end
         end
         mPend = 0;
         c = -1;
         if (vp) begin
            if (int'(cs) <= 8) begin
               if (mBoard[cs] == 0 && !oldWin && !oldTie) c = int'(cs);
            end
            mV = (c >= 0);
         end else if (pr) begin
            s = int'(useL[3:0]) % 9;
            for (int off = 0; off < 9; off++) begin
               idx = (s + off) % 9;
               if (c < 0 && mBoard[idx] == 0) c = idx;
            end
            if (oldWin || oldTie) c = -1;
            mV = (c >= 0);
         end
         if (c >= 0) begin
            mBoard[c] = mPlayer + 1;
            mCount++;
            mPend = mPlayer + 1;
         end
         if (ct) mPlayer = mPlayer ^ 1;
      end
      e.v = mV; e.win = mWin; e.tie = mTie; e.player = mPlayer[0];
      for (int k = 0; k < 9; k++) e.board[2*k +: 2] = 2'(mBoard[k]);
      e.winLine = mWinLine;
      e.count   = 4'(mCount);
      expQ.push_back(e);
   endtask

   task automatic applyStimulus(input logic ng, input logic [3:0] cs, input logic vp, input logic pr, input logic ct);
      @(negedge clk);
      newGame = ng; cellSel = cs; validatePlay = vp; playRandom = pr; changeTurn = ct;
      modelEdge(ng, cs, vp, pr, ct);
   endtask

   task automatic afterEdge();
      @(posedge clk);
      #2;
   endtask

   // Reset is asserted mid-cycle so its asynchronous effect is observed before any clock edge
   task automatic resetDut();
      @(posedge clk);
      #3;
      rst = 1'b0;
      newGame = 1'b0; cellSel = 4'd0; validatePlay = 1'b0; playRandom = 1'b0; changeTurn = 1'b0;
      #1;
      checkOutput("rstV", v, 0);
      checkOutput("rstWin", win, 0);
      checkOutput("rstTie", tie, 0);
      checkOutput("rstPlayer", player, 0);
      checkOutput("rstBoard", board, 0);
      checkOutput("rstWinLine", winLine, 0);
      checkOutput("rstCount", moveCount, 0);
      modelClearGame();
      mLfsr = SEED;
      @(negedge clk);
      rst = 1'b1;
      modelEdge(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic playSequence(input int n, input int cells[9]);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'(cells[i]), 1'b1, 1'b0, 1'b1);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst && expQ.size() != 0) begin
         e = expQ.pop_front();
         checkOutput("v", v, e.v);
         checkOutput("win", win, e.win);
         checkOutput("tie", tie, e.tie);
         checkOutput("player", player, e.player);
         checkOutput("board", board, e.board);
         checkOutput("winLine", winLine, e.winLine);
         checkOutput("moveCount", moveCount, e.count);
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int  rowWin[9]  = '{0, 3, 1, 4, 2, 0, 0, 0, 0};
      int  tieOrder[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
      bit  found;
      logic ng, vp, pr, ct;
      logic [3:0] cs;

      resetDut();

      applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'd4, 1'b1, 1'b0, 1'b0);
      afterEdge();
      checkOutput("legalV", v, 1);
      checkOutput("cell4X", board[9:8], 2'b01);
      checkOutput("legalCount", moveCount, 1);
      applyStimulus(1'b0, 4'd4, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 4'd4, 1'b1, 1'b0, 1'b0);
      afterEdge();
      checkOutput("occupiedV", v, 0);
      checkOutput("playerO", player, 1);
      applyStimulus(1'b0, 4'd11, 1'b1, 1'b0, 1'b0);

      applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
      playSequence(5, rowWin);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      afterEdge();
      checkOutput("rowWin", win, 1);
      checkOutput("rowWinLine", winLine, 8'h01);
      checkOutput("rowWinNoTie", tie, 0);
      applyStimulus(1'b0, 4'd8, 1'b1, 1'b0, 1'b0);

      applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
      playSequence(9, tieOrder);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      afterEdge();
      checkOutput("tieSet", tie, 1);
      checkOutput("tieNoWin", win, 0);
      checkOutput("tieCount", moveCount, 9);

      applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
      playSequence(8, tieOrder);
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         if (int'(mLfsr[3:0]) % 9 == 5) found = 1'b1;
         else applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      end
      checks++;
      if (!found) begin
         errors++;
         $display("[TB] FAIL lfsrWait: start index 5 not reached, got %0d expected 5", int'(mLfsr[3:0]) % 9);
      end
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      afterEdge();
      checkOutput("randWrapV", v, 1);
      checkOutput("randWrapCell8", board[17:16], 2'b01);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

      applyStimulus(1'b1, 4'd3, 1'b1, 1'b0, 1'b1);
      afterEdge();
      checkOutput("prioBoard", board, 0);
      checkOutput("prioPlayer", player, 0);
      checkOutput("prioV", v, 0);
      applyStimulus(1'b0, 4'd2, 1'b1, 1'b1, 1'b0);
      afterEdge();
      checkOutput("prioOneWrite", board, 18'h00010);
      checkOutput("prioCount", moveCount, 1);

      for (int i = 0; i < 800; i++) begin
         if (i == 400) resetDut();
         ng = ($urandom_range(0, 99) < 3);
         vp = ($urandom_range(0, 99) < 45);
         pr = ($urandom_range(0, 99) < 25);
         ct = ($urandom_range(0, 99) < 40);
         cs = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
         applyStimulus(ng, cs, vp, pr, ct);
      end

      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      checkOutput("queueDrained", expQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tictac_board.md
# tictac_board

Board-state and move-arbitration stage for the 3x3 tic-tac-toe game, directly downstream of the game controller FSM. It consumes the controller's `ValidatePlay`, `PlayRandom` and `ChangeTurn` strobes and produces the `V`, `Win`, `Tie` and `Player` inputs that the FSM samples. It holds the board, validates and commits player moves, and picks a random legal cell on timeout. Win/tie detection is registered.

## Interface
- `SEED`, 8'hA5: reset value of the random-cell LFSR; must be non-zero.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `new_game`  in  1  one-cycle strobe: clear board for a new game.
- `cell_sel`  in  4  player's chosen cell, 0..8 row-major (0 = top-left); 9..15 illegal.
- `validate_play`  in  1  one-cycle strobe: validate and commit `cell_sel`.
- `play_random`  in  1  one-cycle strobe: commit a random empty cell.
- `change_turn`  in  1  one-cycle strobe: toggle the current player.
- `v`  out  1  registered result of the last validate/random request.
- `win`  out  1  registered: the mover of the last commit completed a line.
- `tie`  out  1  registered: board full and no win.
- `player`  out  1  current mover: 0 = X, 1 = O.
- `board`  out  18  2 bits per cell, cell k at [2k+1:2k]: 00 empty, 01 X, 10 O; 11 never occurs.
- `win_line`  out  8  one-hot winning line: rows 0-2 [2:0], columns 0-2 [5:3], main diagonal [6], anti-diagonal [7].
- `move_count`  out  4  number of occupied cells, 0..9.

## Operation
- **Reset (`rst`=0):**
  - `board`=0, `player`=0, `v`=0, `win`=0, `tie`=0, `win_line`=0, `move_count`=0, LFSR=`SEED`.
  - Takes effect immediately and asynchronously, including mid-request; the pending request is discarded.
- **LFSR:** 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Steps every cycle outside reset and is never cleared by `new_game`.
- **Request priority per cycle:** `new_game` > `validate_play` > `play_random`. At most one board write per cycle.
- **`new_game`:**
  - Same effect as reset except the LFSR keeps running.
  - Any `validate_play`/`play_random` in the same cycle is ignored.
  - A simultaneous `change_turn` is also ignored: `player` ends at 0.
- **`validate_play` legal case:** legal when `cell_sel`≤8, the cell is empty, and `win`=0.
  - Write the cell with the current `player`.
  - Increment `move_count`.
  - Set `v`=1.
- **`validate_play` illegal case:** `v`=0; board and count unchanged.
- **`play_random`:**
  - Start index s = LFSR[3:0] mod 9.
  - Pick the first empty cell scanning s, s+1, … wrapping 8→0. This is a combinational rotating priority search, single cycle.
  - If an empty cell exists and `win`=0: write it, increment `move_count`, set `v`=1. Otherwise `v`=0.
- **`v`** holds its value until the next request or `new_game` (which clears it).
- **Win/tie evaluation:**
  - The cycle after any commit, evaluate all 8 lines for the mark just written.
  - `win`=1 if any line is complete; `win_line` gets the one-hot of the lowest-index complete line.
  - `tie`=1 iff `move_count`=9 and no line is complete.
  - `win`/`tie` are sticky until `new_game`/reset.
  - `win` and `tie` are never both 1.
- **`change_turn`:** toggles `player`. If it coincides with a commit, the commit uses the pre-toggle `player`.
- **Game over:** once `win`=1 or `tie`=1, all further requests return `v`=0 with no board change.

## Timing
- Request sampled at edge N:
  - `v`, `board` and `move_count` are valid after edge N.
  - `win`, `tie` and `win_line` are valid after edge N+1.
- This matches the controller: it samples `v` one state after asserting the strobe, and `win`/`tie` one state after that.
- `player` changes at the edge where `change_turn` is sampled.
- No back-pressure and no busy signal: the block accepts a request every cycle.
- Back-to-back commits in consecutive cycles are legal. The win evaluation for commit N+1 sees the board including commit N.

## Test plan
- **Reset state:** drive `rst`=0 asynchronously mid-cycle → all outputs 0 immediately; after release, LFSR first value is 8'hA5.
- **Legal then illegal move:** `cell_sel`=4, `validate_play` → `v`=1, `board`[9:8]=01, `move_count`=1. Then `change_turn`; `cell_sel`=4, `validate_play` → `v`=0, board unchanged, `player`=1. Then `cell_sel`=11 → `v`=0.
- **Row win:** X at cells 0,1,2 with O at 3,4, alternating with `change_turn` → two cycles after the third X write: `win`=1, `win_line`=8'b0000_0001, `tie`=0. A further `validate_play` at cell 8 → `v`=0.
- **Tie:** fill X,O,X / X,O,O / O,X,X (cells 0..8 in play order 0,1,2,4,3,5,7,6,8) → after the ninth commit, `move_count`=9, `tie`=1, `win`=0.
- **Random play with wrap:** fill cells 0..7 without a win, force LFSR so s=5, `play_random` → cell 8 written with the current player, `v`=1. A second `play_random` on the now-full board → `v`=0.
- **Priority/simultaneity:** `new_game`, `validate_play` and `change_turn` in the same cycle → board 0, `player`=0, `v`=0. Then `validate_play` + `play_random` together on empty cell 2 → only cell 2 written, `move_count`=1.
